// File: rtl/bus_demux3.sv
// Single-outstanding memory-bus demultiplexer: decodes the master address onto one of
// three slave ports and returns the slave response, or an error for unmapped or stalled accesses.
module bus_demux3 #(
  parameter logic [31:0] BASE0   = 32'h0000_0000,
  parameter logic [31:0] MASK0   = 32'hFFFF_0000,
  parameter logic [31:0] BASE1   = 32'h8000_0000,
  parameter logic [31:0] MASK1   = 32'hFFFF_FF00,
  parameter logic [31:0] BASE2   = 32'h8000_0100,
  parameter logic [31:0] MASK2   = 32'hFFFF_FF00,
  parameter int          TIMEOUT = 255
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [31:0] I_req_addr,
  input  logic        I_req_we,
  input  logic [31:0] I_req_wdata,
  input  logic [3:0]  I_req_wstrb,
  output logic        O_resp_valid,
  output logic [31:0] O_resp_rdata,
  output logic        O_resp_err,
  output logic [2:0]  O_s_valid,
  input  logic [2:0]  I_s_ready,
  output logic [31:0] O_s_addr,
  output logic        O_s_we,
  output logic [31:0] O_s_wdata,
  output logic [3:0]  O_s_wstrb,
  input  logic [2:0]  I_s_resp_valid,
  input  logic [31:0] I_s_rdata0,
  input  logic [31:0] I_s_rdata1,
  input  logic [31:0] I_s_rdata2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  hit;
  logic [2:0]  sel_oh;
  logic        timed_out;
  logic        slave_ready;
  logic        slave_resp;
  logic [31:0] slave_rdata;

  assign hit[0] = (I_req_addr & MASK0) == BASE0;
  assign hit[1] = (I_req_addr & MASK1) == BASE1;
  assign hit[2] = (I_req_addr & MASK2) == BASE2;

  // One-hot form of sel keeps every per-slave lookup in range even for the unused code 3.
  assign sel_oh      = 3'b001 << sel_q;
  assign timed_out   = (cnt_q == TO);
  assign slave_ready = |(I_s_ready & sel_oh);
  assign slave_resp  = |(I_s_resp_valid & sel_oh);

  always_comb begin
    case (sel_q)
      2'd0:    slave_rdata = I_s_rdata0;
      2'd1:    slave_rdata = I_s_rdata1;
      default: slave_rdata = I_s_rdata2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (I_req_valid) begin
          addr_d  = I_req_addr;
          we_d    = I_req_we;
          wdata_d = I_req_wdata;
          wstrb_d = I_req_wstrb;
          cnt_d   = 16'd0;
          if (hit[0]) begin
            sel_d   = 2'd0;
            state_d = S_ISSUE;
          end else if (hit[1]) begin
            sel_d   = 2'd1;
            state_d = S_ISSUE;
          end else if (hit[2]) begin
            sel_d   = 2'd2;
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (timed_out)        state_d = S_ERR;
        else if (slave_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the same cycle the limit is hit still counts as a normal completion.
        if (slave_resp) begin
          rdata_d = we_q ? 32'd0 : slave_rdata;
          state_d = S_RESP;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 16'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign O_req_ready  = (state_q == S_IDLE);
  assign O_s_valid    = (state_q == S_ISSUE && !timed_out) ? sel_oh : 3'b000;
  assign O_s_addr     = addr_q;
  assign O_s_we       = we_q;
  assign O_s_wdata    = wdata_q;
  assign O_s_wstrb    = wstrb_q;
  assign O_resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
  assign O_resp_err   = (state_q == S_ERR);
  assign O_resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_bus_demux3.sv
// Directed bench for bus_demux3: expected responses are queued at request time and
// compared by a monitor whenever the block emits a response pulse.
module tb_bus_demux3;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_req_valid;
  logic        O_req_ready;
  logic [31:0] I_req_addr;
  logic        I_req_we;
  logic [31:0] I_req_wdata;
  logic [3:0]  I_req_wstrb;
  logic        O_resp_valid;
  logic [31:0] O_resp_rdata;
  logic        O_resp_err;
  logic [2:0]  O_s_valid;
  logic [2:0]  I_s_ready;
  logic [31:0] O_s_addr;
  logic        O_s_we;
  logic [31:0] O_s_wdata;
  logic [3:0]  O_s_wstrb;
  logic [2:0]  I_s_resp_valid;
  logic [31:0] I_s_rdata0, I_s_rdata1, I_s_rdata2;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb[$];  // {err, rdata}

  bus_demux3 #(.TIMEOUT(8)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
    .I_req_addr(I_req_addr), .I_req_we(I_req_we),
    .I_req_wdata(I_req_wdata), .I_req_wstrb(I_req_wstrb),
    .O_resp_valid(O_resp_valid), .O_resp_rdata(O_resp_rdata), .O_resp_err(O_resp_err),
    .O_s_valid(O_s_valid), .I_s_ready(I_s_ready),
    .O_s_addr(O_s_addr), .O_s_we(O_s_we), .O_s_wdata(O_s_wdata), .O_s_wstrb(O_s_wstrb),
    .I_s_resp_valid(I_s_resp_valid),
    .I_s_rdata0(I_s_rdata0), .I_s_rdata1(I_s_rdata1), .I_s_rdata2(I_s_rdata2)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge I_clk);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic exp_err, input logic [31:0] exp_rdata);
    I_req_valid = 1'b1;
    I_req_addr  = addr;
    I_req_we    = we;
    I_req_wdata = wdata;
    I_req_wstrb = wstrb;
    sb.push_back({exp_err, exp_rdata});
    $display("request addr=%h we=%0d wdata=%h wstrb=%b", addr, we, wdata, wstrb);
  endtask

  // Scoreboard side: every response pulse must match the oldest queued expectation.
  always @(negedge I_clk) begin
    if (!I_rst && O_resp_valid) begin
      logic [32:0] e;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_err", {31'd0, O_resp_err}, {31'd0, e[32]});
        check("resp_rdata", O_resp_rdata, e[31:0]);
        $display("response err=%0d rdata=%h", O_resp_err, O_resp_rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst = 1'b1; I_req_valid = 1'b0; I_req_addr = '0; I_req_we = 1'b0;
    I_req_wdata = '0; I_req_wstrb = '0; I_s_ready = '0; I_s_resp_valid = '0;
    I_s_rdata0 = '0; I_s_rdata1 = '0; I_s_rdata2 = '0;
    nc(); nc();
    check("rst_ready", {31'd0, O_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, O_resp_valid}, 32'd0);
    check("rst_s_valid", {29'd0, O_s_valid}, 32'd0);
    check("rst_s_addr", O_s_addr, 32'd0);
    I_rst = 1'b0;
    nc();

    // Read slave 0, immediate ready, response one cycle after handshake.
    drive_req(32'h0000_0010, 1'b0, 32'd0, 4'd0, 1'b0, 32'hDEAD_BEEF);
    I_s_ready = 3'b001;
    nc();
    check("t1_s_valid_c1", {29'd0, O_s_valid}, 32'd1);
    I_req_valid = 1'b0;
    nc();
    check("t1_s_valid_c2", {29'd0, O_s_valid}, 32'd0);
    I_s_ready = 3'b000; I_s_resp_valid = 3'b001; I_s_rdata0 = 32'hDEAD_BEEF;
    nc();
    I_s_resp_valid = 3'b000;
    check("t1_resp_c3", {31'd0, O_resp_valid}, 32'd1);
    check("t1_ready_c3", {31'd0, O_req_ready}, 32'd0);
    nc();
    check("t1_ready_c4", {31'd0, O_req_ready}, 32'd1);
    check("t1_resp_c4", {31'd0, O_resp_valid}, 32'd0);

    // Write slave 1 with four stalled cycles; request fields change after acceptance.
    I_s_rdata1 = 32'hCAFE_F00D;
    drive_req(32'h8000_0004, 1'b1, 32'h0000_0055, 4'b0001, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      nc();
      I_req_valid = 1'b0; I_req_addr = 32'h1234_5678; I_req_wdata = '1; I_req_wstrb = 4'hF;
      check("t2_s_valid", {29'd0, O_s_valid}, 32'd2);
      check("t2_s_addr", O_s_addr, 32'h8000_0004);
      check("t2_s_wdata", O_s_wdata, 32'h0000_0055);
      check("t2_s_wstrb", {28'd0, O_s_wstrb}, 32'd1);
      check("t2_s_we", {31'd0, O_s_we}, 32'd1);
      if (i == 4) I_s_ready = 3'b010;
    end
    nc();
    check("t2_s_valid_wait", {29'd0, O_s_valid}, 32'd0);
    I_s_ready = 3'b000; I_s_resp_valid = 3'b010;
    nc();
    I_s_resp_valid = 3'b000;
    check("t2_resp", {31'd0, O_resp_valid}, 32'd1);
    nc();

    // Unmapped read.
    drive_req(32'h4000_0000, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0);
    nc();
    I_req_valid = 1'b0;
    check("t3_resp_c1", {31'd0, O_resp_valid}, 32'd1);
    check("t3_err_c1", {31'd0, O_resp_err}, 32'd1);
    check("t3_s_valid", {29'd0, O_s_valid}, 32'd0);
    check("t3_ready_c1", {31'd0, O_req_ready}, 32'd0);
    nc();
    check("t3_ready_c2", {31'd0, O_req_ready}, 32'd1);

    // Slave 2 never responds: error pulse 9 cycles after ISSUE entry, late response ignored.
    drive_req(32'h8000_0100, 1'b0, 32'd0, 4'd0, 1'b1, 32'd0);
    I_s_ready = 3'b100; I_s_rdata2 = 32'h7777_7777;
    nc();
    I_req_valid = 1'b0;
    check("t4_s_valid", {29'd0, O_s_valid}, 32'd4);
    for (int c = 2; c <= 9; c++) begin
      nc();
      I_s_ready = 3'b000;
      check("t4_no_resp_early", {31'd0, O_resp_valid}, 32'd0);
    end
    nc();
    check("t4_err_pulse", {31'd0, O_resp_err & O_resp_valid}, 32'd1);
    I_s_resp_valid = 3'b100;
    nc();
    nc();
    I_s_resp_valid = 3'b000;
    check("t4_late_ignored", {31'd0, O_resp_valid}, 32'd0);

    // Response in the very cycle the counter hits the limit wins over the timeout.
    drive_req(32'h8000_0180, 1'b0, 32'd0, 4'd0, 1'b0, 32'h1234_5678);
    I_s_ready = 3'b100; I_s_rdata2 = 32'h1234_5678;
    nc();
    I_req_valid = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      nc();
      I_s_ready = 3'b000;
      if (c == 9) I_s_resp_valid = 3'b100;
    end
    nc();
    I_s_resp_valid = 3'b000;
    check("t4b_resp_at_limit", {31'd0, O_resp_valid}, 32'd1);
    nc();

    // Stray slave 0 responses in IDLE and while slave 1 is selected.
    I_s_resp_valid = 3'b001; I_s_rdata0 = 32'h0000_0BAD;
    nc();
    check("t5_idle_stray", {31'd0, O_resp_valid}, 32'd0);
    drive_req(32'h8000_0008, 1'b0, 32'd0, 4'd0, 1'b0, 32'hA5A5_0001);
    nc();
    I_req_valid = 1'b0; I_s_ready = 3'b010;
    nc();
    I_s_ready = 3'b000;
    nc();
    check("t5_wait_stray", {31'd0, O_resp_valid}, 32'd0);
    I_s_resp_valid = 3'b011; I_s_rdata1 = 32'hA5A5_0001;
    nc();
    I_s_resp_valid = 3'b000;
    check("t5_resp", {31'd0, O_resp_valid}, 32'd1);
    nc();

    // Reset in WAIT aborts the transaction; the pending slave response is dropped.
    sb.push_back(33'h0);  // aborted request never responds, so nothing stays queued
    void'(sb.pop_back());
    I_req_valid = 1'b1; I_req_addr = 32'h0000_0020; I_req_we = 1'b0;
    I_s_ready = 3'b001;
    $display("request addr=00000020 we=0 (to be aborted)");
    nc();
    I_req_valid = 1'b0;
    nc();
    I_s_ready = 3'b000;
    I_rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, O_req_ready}, 32'd1);
    check("t6_rst_resp", {31'd0, O_resp_valid}, 32'd0);
    check("t6_rst_s_valid", {29'd0, O_s_valid}, 32'd0);
    check("t6_rst_s_addr", O_s_addr, 32'd0);
    I_s_resp_valid = 3'b001; I_s_rdata0 = 32'h0000_0BAD;
    nc();
    I_rst = 1'b0;
    nc();
    I_s_resp_valid = 3'b000;
    check("t6_dropped", {31'd0, O_resp_valid}, 32'd0);
    drive_req(32'h0000_0024, 1'b0, 32'd0, 4'd0, 1'b0, 32'h0BEE_F00D);
    I_s_ready = 3'b001;
    nc();
    I_req_valid = 1'b0;
    nc();
    I_s_ready = 3'b000; I_s_resp_valid = 3'b001; I_s_rdata0 = 32'h0BEE_F00D;
    nc();
    I_s_resp_valid = 3'b000;
    check("t6_after_rst_resp", {31'd0, O_resp_valid}, 32'd1);
    nc(); nc();

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_demux3.md
# bus_demux3

Routes single-master memory-bus transactions from the CPU load/store unit to one of three slave ports (RAM, UART, GPIO) by address decode. It returns the selected slave's response to the master and generates an error response for unmapped addresses or unresponsive slaves. It sits between the CPU data port and the SoC peripherals and handles one outstanding transaction at a time.

## Interface
- BASE0, 32'h0000_0000, slave 0 base address
- MASK0, 32'hFFFF_0000, slave 0 decode mask (match when (addr & MASK0) == BASE0)
- BASE1, 32'h8000_0000, slave 1 base address
- MASK1, 32'hFFFF_FF00, slave 1 decode mask
- BASE2, 32'h8000_0100, slave 2 base address
- MASK2, 32'hFFFF_FF00, slave 2 decode mask
- TIMEOUT, 255, cycles allowed in ISSUE+WAIT before error (1..65535)

Ports:
- I_clk  input  1  clock; all state on rising edge
- I_rst  input  1  asynchronous, active-high reset
- I_req_valid  input  1  master request valid
- O_req_ready  output  1  block can accept a request
- I_req_addr  input  32  request byte address
- I_req_we  input  1  1 = write, 0 = read
- I_req_wdata  input  32  write data
- I_req_wstrb  input  4  byte write strobes
- O_resp_valid  output  1  one-cycle response pulse to master
- O_resp_rdata  output  32  read data (0 for writes and errors)
- O_resp_err  output  1  qualifies O_resp_valid: unmapped address or timeout
- O_s_valid  output  3  per-slave request valid, one-hot or zero
- I_s_ready  input  3  per-slave request accept
- O_s_addr, O_s_we, O_s_wdata, O_s_wstrb  output  32/1/32/4  latched request broadcast to all slaves
- I_s_resp_valid  input  3  per-slave response valid
- I_s_rdata0, I_s_rdata1, I_s_rdata2  input  32 each  per-slave read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- O_req_ready = (state == IDLE). It is combinational from state only.
- IDLE: when I_req_valid is 1, latch addr/we/wdata/wstrb into the O_s_* registers and decode.
  - Priority is 0 > 1 > 2 when windows overlap.
  - Match on slave j: sel <= j, clear the timeout counter, go to ISSUE.
  - No match: go to ERR.
- ISSUE: O_s_valid[sel] = 1.
  - When I_s_ready[sel] is 1, go to WAIT.
  - O_s_valid drops in the cycle after the handshake.
- WAIT: on I_s_resp_valid[sel], capture rdata (mux by sel; 0 if the request was a write) and go to RESP.
- RESP: O_resp_valid = 1, O_resp_err = 0 for exactly one cycle, then IDLE.
- ERR: O_resp_valid = 1, O_resp_err = 1, O_resp_rdata = 0 for exactly one cycle, then IDLE.
- Timeout: a 16-bit counter increments every cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT, go to ERR. O_s_valid deasserts immediately.
  - A late slave response after the timeout is ignored.
- Ignored inputs:
  - I_s_resp_valid from unselected slaves, at any time.
  - Any I_s_resp_valid outside WAIT, including in the ISSUE handshake cycle. Slaves respond no earlier than one cycle after the ready handshake.
- Master has no response back-pressure; the CPU accepts O_resp_valid unconditionally.
- I_req_* are sampled only in the IDLE acceptance cycle; later changes have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so O_req_ready = 1.
  - O_resp_valid = 0, O_resp_err = 0, O_resp_rdata = 0, O_s_valid = 3'b000, O_s_addr/we/wdata/wstrb = 0, counter = 0.
- Reset mid-transaction aborts it. No response is produced and any pending slave response is dropped.
- Mapped read, slave ready immediately, slave responds r cycles after the handshake (r >= 1):
  - Cycle 0: accept.
  - Cycle 1: O_s_valid high, handshake.
  - Cycle 1+r: slave response sampled.
  - Cycle 2+r: O_resp_valid high.
  - Minimum accept-to-response latency is 3 cycles.
- Unmapped access: accept at cycle 0, O_resp_valid/O_resp_err at cycle 1, O_req_ready high again at cycle 2.
- Back-to-back: the next request is accepted no earlier than the cycle after the response pulse.
- Timeout boundary: the counter is 0 in the first ISSUE cycle. The error pulse appears TIMEOUT+1 cycles after entering ISSUE if no response arrives.
- A response arriving in the same WAIT cycle the counter hits TIMEOUT wins: normal RESP, not an error.

## Test plan
- Read 0x0000_0010, slave 0 ready at once, returns 0xDEADBEEF one cycle later -> O_resp_valid at cycle 3, rdata = 0xDEADBEEF, err = 0, O_s_valid = 3'b001 for exactly one cycle.
- Write 0x8000_0004 data 0x55, wstrb 4'b0001, slave 1 holds ready low 4 cycles -> O_s_valid[1] held 5 cycles with stable O_s_addr/wdata/wstrb, then response with rdata = 0, err = 0.
- Read 0x4000_0000 (unmapped) -> O_s_valid stays 0, response at cycle 1 with err = 1, rdata = 0, ready again at cycle 2.
- Read 0x8000_0100, slave 2 never responds, TIMEOUT = 8 -> err = 1 pulse 9 cycles after ISSUE entry; a later I_s_resp_valid[2] produces no response.
- Slave 0 asserts resp_valid while slave 1 is selected and during IDLE -> no O_resp_valid; the slave 1 response is delivered normally.
- Assert I_rst in WAIT -> all outputs 0 and O_req_ready = 1 at once; the next request completes normally.
